// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch control stage.
//   fetch_state_e     - 3-bit FSM state encoding
//   NOP_INST          - value presented on dec_inst while nothing was fetched
//   RESET_VEC_DEFAULT - default fetch PC after reset
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_KILL = 3'd3,
    ST_HOLD = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INST          = 32'h0000_0013;
  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_ifu.sv
// fetch_ifu: instruction-fetch control stage.
//   Owns the fetch PC register (fe_pc, fed back to the PC-select mux), runs a
//   single-outstanding req/gnt/rvalid transaction on the instruction memory
//   port and presents each fetched word plus its PC to decode on a
//   valid/ready handshake. Execute redirects (pc_sel) flush anything in
//   flight or held.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   pc_in, next_pc_in            - mux PC and PC+4
//   pc_sel                       - redirect pulse (pc_in is the target)
//   fetch_en                     - 0 stops new requests
//   fe_pc                        - registered fetch PC
//   imem_req/addr/gnt/rvalid/rdata - instruction memory port
//   dec_valid/inst/pc/misalign/ready - decode handshake
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; waiting for fetch_en
// REQ   | imem_req high, address held until granted
// WAIT  | granted, waiting for the response
// KILL  | granted on the wrong path; next response is dropped
// HOLD  | instruction presented to decode until accepted
module fetch_ifu
  import fetch_pkg::*;
#(
  parameter int              W         = 32,
  parameter logic [W-1:0]    RESET_VEC = W'(RESET_VEC_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] next_pc_in,
  input  logic         pc_sel,
  input  logic         fetch_en,
  output logic [W-1:0] fe_pc,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [W-1:0] imem_rdata,
  output logic         dec_valid,
  output logic [W-1:0] dec_inst,
  output logic [W-1:0] dec_pc,
  output logic         dec_misalign,
  input  logic         dec_ready
);

  fetch_state_e state_q;
  logic [W-1:0] fe_pc_q;
  logic [W-1:0] req_addr_q;
  logic         imem_req_q;
  logic         dec_valid_q;
  logic [W-1:0] dec_inst_q;
  logic [W-1:0] dec_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fe_pc_q     <= RESET_VEC;
      req_addr_q  <= RESET_VEC;
      imem_req_q  <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_inst_q  <= W'(NOP_INST);
      dec_pc_q    <= RESET_VEC;
    end else begin
      // A redirect always retargets the fetch PC, whatever the state.
      if (pc_sel) begin
        fe_pc_q <= pc_in + W'(4);
      end

      case (state_q)
        ST_IDLE: begin
          if (fetch_en) begin
            state_q    <= ST_REQ;
            req_addr_q <= pc_in;
            imem_req_q <= 1'b1;
          end
        end

        ST_REQ: begin
          // Not yet granted: simply swap the address. If the grant lands in
          // the same cycle, the old address went out and must be killed.
          if (pc_sel) begin
            req_addr_q <= pc_in;
          end
          if (imem_gnt) begin
            imem_req_q <= 1'b0;
            state_q    <= pc_sel ? ST_KILL : ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (pc_sel) begin
            req_addr_q <= pc_in;
            if (imem_rvalid) begin
              // Response arrives with the redirect: it is already stale.
              state_q    <= fetch_en ? ST_REQ : ST_IDLE;
              imem_req_q <= fetch_en;
            end else begin
              state_q <= ST_KILL;
            end
          end else if (imem_rvalid) begin
            dec_inst_q  <= imem_rdata;
            dec_pc_q    <= req_addr_q;
            fe_pc_q     <= next_pc_in;
            dec_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end

        ST_KILL: begin
          if (pc_sel) begin
            req_addr_q <= pc_in;
          end
          if (imem_rvalid) begin
            state_q    <= fetch_en ? ST_REQ : ST_IDLE;
            imem_req_q <= fetch_en;
          end
        end

        ST_HOLD: begin
          // Redirect and accept both release the slot; with a redirect the
          // held word is simply dropped instead of consumed.
          if (pc_sel || dec_ready) begin
            dec_valid_q <= 1'b0;
            if (fetch_en) begin
              state_q    <= ST_REQ;
              req_addr_q <= pc_in;
              imem_req_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          imem_req_q  <= 1'b0;
          dec_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fe_pc        = fe_pc_q;
  assign imem_req     = imem_req_q;
  assign imem_addr    = req_addr_q;
  assign dec_valid    = dec_valid_q;
  assign dec_inst     = dec_inst_q;
  assign dec_pc       = dec_pc_q;
  assign dec_misalign = dec_valid_q & (dec_pc_q[1:0] != 2'b00);

endmodule

// File: doc/fetch_ifu.md
# fetch_ifu

Instruction-fetch control stage directly downstream of the PC-select mux (`fetch_top`). It owns the architectural fetch PC register and feeds it back to the mux's `nextPC_fe` input. It runs a single-outstanding request/grant/response transaction on the instruction memory port and hands each fetched word, with its PC, to decode over a valid/ready handshake. Execute-stage redirects (`pc_sel`) flush any in-flight or held instruction.

## Interface
- `W`, 32: data/address width.
- `RESET_VEC`, 32'h0000_0000: fetch PC after reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc_in` input W: mux output `PC`; the address to fetch this cycle.
- `next_pc_in` input W: mux output `nextPC` (`pc_in + 4`).
- `pc_sel` input 1: redirect pulse from execute, one cycle; `pc_in` is the target while high.
- `fetch_en` input 1: 0 suspends new requests (WFI/sleep).
- `fe_pc` output W: registered fetch PC; drives mux `nextPC_fe`.
- `imem_req` output 1: request valid.
- `imem_addr` output W: request address, held stable while `imem_req` is high.
- `imem_gnt` input 1: request accepted this cycle.
- `imem_rvalid` input 1: response valid, at least 1 cycle after grant.
- `imem_rdata` input W: instruction word.
- `dec_valid` output 1: instruction available to decode.
- `dec_inst` output W: instruction word.
- `dec_pc` output W: PC of `dec_inst`.
- `dec_misalign` output 1: `dec_pc[1:0] != 0`; qualified by `dec_valid`.
- `dec_ready` input 1: decode accepts this cycle.

## Operation
- FSM states: IDLE, REQ, WAIT, KILL, HOLD.
- IDLE: entered from reset. Go to REQ when `fetch_en` is high.
- REQ: `imem_req`=1 and `imem_addr`=`req_addr_q`. The address is latched from `pc_in` on entry and held until granted.
  - On `imem_gnt` → WAIT.
- WAIT: wait for `imem_rvalid`.
  - On `imem_rvalid`: capture `imem_rdata` into `dec_inst`, `req_addr_q` into `dec_pc`, and `next_pc_in` into `fe_pc`, then go to HOLD.
- HOLD: `dec_valid`=1; outputs are stable until accepted.
  - On `dec_ready`: if `fetch_en`, go to REQ with address = `pc_in`; else go to IDLE.
- Redirect (`pc_sel`=1):
  - `fe_pc` loads `pc_in + 4`.
  - In IDLE or HOLD: drop the held instruction. Go to REQ with `req_addr_q`=`pc_in`, or to IDLE if `fetch_en`=0.
  - In REQ before grant: replace `req_addr_q` with `pc_in`. If `imem_gnt` is high in the same cycle, the old address was granted, so go to KILL.
  - In WAIT: latch the target into `req_addr_q` and go to KILL.
- KILL: discard the next `imem_rvalid` response; `dec_valid` stays 0. Then go to REQ with the latched target, or IDLE if `fetch_en`=0.
- Redirect arriving in the same cycle as `imem_rvalid` in WAIT: the response is discarded; go to REQ with the target.
- Redirect has priority over `dec_ready`. Decode never sees a wrong-path instruction.
- `fetch_en` falling: an outstanding transaction completes normally. No new request issues.
- Misaligned PC: the fetch is issued normally with `imem_addr` = PC (bits [1:0] forwarded) and `dec_misalign`=1. Trap handling belongs to decode/execute.

## Timing
- Reset values: state=IDLE, `fe_pc`=`RESET_VEC`, `imem_req`=0, `imem_addr`=`RESET_VEC`, `dec_valid`=0, `dec_inst`=32'h0000_0013 (NOP), `dec_pc`=`RESET_VEC`, `dec_misalign`=0.
- Reset mid-transaction: everything returns to reset values immediately. A late `imem_rvalid` after reset release while in IDLE/REQ is ignored.
- All outputs are registered except `dec_misalign`, which is decoded from `dec_pc`.
- Latency, zero wait-states (gnt in REQ's first cycle, rvalid the next cycle):
  - `fetch_en` high → `imem_req` 1 cycle later.
  - Grant → `dec_valid` 2 cycles later.
  - Throughput: one instruction per 3 cycles.
- PC arithmetic is modulo 2^W; 32'hFFFF_FFFC + 4 wraps to 0.

## Structure
- Shared package `fetch_pkg`: FSM state encoding (3 bits), the NOP constant, and `RESET_VEC` default.
- No sub-module. The FSM, PC register and decode output register live in one module; `fetch_top` is instantiated by the parent, not here.

## Test plan
- Reset/boot: release `rst_n` with `fetch_en`=1; gnt and rvalid return immediately with rdata=32'h00500093 → `imem_addr`=0, `dec_valid` with `dec_pc`=0, `dec_inst`=32'h00500093; `fe_pc`=4 after decode accept.
- Backpressure: hold `dec_ready`=0 for 5 cycles → `dec_inst`/`dec_pc` stable and no new `imem_req`; accept → next request at 4.
- Grant stall: delay gnt 3 cycles → `imem_req` and `imem_addr` held constant the whole time.
- Redirect in WAIT: `pc_sel`=1 with `pc_in`=32'h100 while waiting → stale response discarded (no `dec_valid`), next request at 32'h100, `fe_pc`=32'h104.
- Redirect in HOLD with `dec_ready`=1 in the same cycle → instruction not consumed, next fetch at the target.
- Misalign/wrap: redirect to 32'h102 → `dec_misalign`=1; fetch at 32'hFFFF_FFFC → `fe_pc`=0.
